// File: rtl/guess_entry_ctrl.sv
// Purpose : player digit entry for the guessing game; increment/decrement per digit, confirm, attempt tracking, lockout.
// Latency : a raw button first sampled at edge k acts at edge k+2; guess_valid rises at the confirm action edge.
// Backpress: guess_valid holds the latched guess until guess_ack; all button edges are dropped while a guess is pending.
//
// Ports:
//   clk, restart          clock and asynchronous active-high reset
//   max_digits            active digit count (clamped to NUM_DIGITS)
//   inc_btn, dec_btn      raw per-digit buttons; confirm raw confirm button
//   guess_ack, guess_hit  comparator acceptance and hit qualifier
//   display_digits        live entry digits, 4 bits each
//   guess_digits          latched guess, guess_valid pending flag
//   attempts_used, won, out_of_attempts, locked   game status
module guess_entry_ctrl #(
    parameter int NUM_DIGITS   = 3,
    parameter int RADIX        = 10,
    parameter int MAX_ATTEMPTS = 7,
    parameter int ATTEMPT_W    = 4
) (
    input  logic                      clk,
    input  logic                      restart,
    input  logic [3:0]                max_digits,
    input  logic [NUM_DIGITS-1:0]     inc_btn,
    input  logic [NUM_DIGITS-1:0]     dec_btn,
    input  logic                      confirm,
    input  logic                      guess_ack,
    input  logic                      guess_hit,
    output logic [4*NUM_DIGITS-1:0]   display_digits,
    output logic [4*NUM_DIGITS-1:0]   guess_digits,
    output logic                      guess_valid,
    output logic [ATTEMPT_W-1:0]      attempts_used,
    output logic                      won,
    output logic                      out_of_attempts,
    output logic                      locked
);

    localparam logic [3:0]           DIGIT_MAX = 4'(RADIX - 1);
    localparam logic [ATTEMPT_W-1:0] ATT_LIMIT = ATTEMPT_W'(MAX_ATTEMPTS);
    localparam bit                   LIMITED   = (MAX_ATTEMPTS != 0);

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        PENDING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state;

    // Three-flop chains: two for metastability, the third to find the rising edge.
    logic [NUM_DIGITS-1:0] inc_s1, inc_s2, inc_s3;
    logic [NUM_DIGITS-1:0] dec_s1, dec_s2, dec_s3;
    logic                  conf_s1, conf_s2, conf_s3;

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            inc_s1  <= '0;
            inc_s2  <= '0;
            inc_s3  <= '0;
            dec_s1  <= '0;
            dec_s2  <= '0;
            dec_s3  <= '0;
            conf_s1 <= 1'b0;
            conf_s2 <= 1'b0;
            conf_s3 <= 1'b0;
        end else begin
            inc_s1  <= inc_btn;
            inc_s2  <= inc_s1;
            inc_s3  <= inc_s2;
            dec_s1  <= dec_btn;
            dec_s2  <= dec_s1;
            dec_s3  <= dec_s2;
            conf_s1 <= confirm;
            conf_s2 <= conf_s1;
            conf_s3 <= conf_s2;
        end
    end

    logic [NUM_DIGITS-1:0] inc_edge, dec_edge;
    logic                  conf_edge;

    assign inc_edge  = inc_s2 & ~inc_s3;
    assign dec_edge  = dec_s2 & ~dec_s3;
    assign conf_edge = conf_s2 & ~conf_s3;

    logic [3:0] active_cnt;
    assign active_cnt = (max_digits > 4'(NUM_DIGITS)) ? 4'(NUM_DIGITS) : max_digits;

    // digit_nxt: entry update with button edges applied.
    // digit_clr: only the inactive-digit clearing, used on the confirm cycle
    // where digit edges are discarded.
    logic [4*NUM_DIGITS-1:0] digit_nxt;
    logic [4*NUM_DIGITS-1:0] digit_clr;

    always_comb begin
        digit_nxt = display_digits;
        digit_clr = display_digits;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (4'(i) >= active_cnt) begin
                digit_nxt[4*i +: 4] = 4'd0;
                digit_clr[4*i +: 4] = 4'd0;
            end else if (inc_edge[i] && !dec_edge[i]) begin
                digit_nxt[4*i +: 4] = (display_digits[4*i +: 4] == DIGIT_MAX)
                                      ? 4'd0 : display_digits[4*i +: 4] + 4'd1;
            end else if (dec_edge[i] && !inc_edge[i]) begin
                digit_nxt[4*i +: 4] = (display_digits[4*i +: 4] == 4'd0)
                                      ? DIGIT_MAX : display_digits[4*i +: 4] - 4'd1;
            end
        end
    end

    logic [ATTEMPT_W-1:0] attempts_nxt;
    assign attempts_nxt = (&attempts_used) ? attempts_used : attempts_used + 1'b1;

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            state           <= ENTRY;
            display_digits  <= '0;
            guess_digits    <= '0;
            guess_valid     <= 1'b0;
            attempts_used   <= '0;
            won             <= 1'b0;
            out_of_attempts <= 1'b0;
        end else begin
            case (state)
                ENTRY: begin
                    if (conf_edge) begin
                        guess_digits   <= display_digits;
                        guess_valid    <= 1'b1;
                        display_digits <= digit_clr;
                        state          <= PENDING;
                    end else begin
                        display_digits <= digit_nxt;
                    end
                end
                PENDING: begin
                    if (guess_ack) begin
                        guess_valid   <= 1'b0;
                        attempts_used <= attempts_nxt;
                        if (guess_hit) begin
                            won   <= 1'b1;
                            state <= LOCKED;
                        end else if (LIMITED && attempts_nxt == ATT_LIMIT) begin
                            out_of_attempts <= 1'b1;
                            state           <= LOCKED;
                        end else begin
                            state <= ENTRY;
                        end
                    end
                end
                LOCKED: begin
                    state <= LOCKED;
                end
                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

    assign locked = won | out_of_attempts;

endmodule

// File: doc/guess_entry_ctrl.md
Name: guess_entry_ctrl

Overview:
- Parametrised player digit-entry controller for the number-guessing game; successor to the fixed 3-digit entry logic.
- Supports NUM_DIGITS digits in a configurable radix, with increment and decrement per digit, plus on-chip synchronisation and edge detection of the raw pushbuttons.
- Presents a confirmed guess to the comparator with a valid/ack handshake.
- Tracks attempts and locks entry when the game is won or attempts are exhausted.

Parameters:
- NUM_DIGITS, 3, number of entry digits (1..8).
- RADIX, 10, digit range 0..RADIX-1 (2..16); each digit is 4 bits wide.
- MAX_ATTEMPTS, 7, guesses allowed before lockout; 0 = unlimited.
- ATTEMPT_W, 4, width of the attempt counter.

Ports:
- clk  in  1  system clock.
- restart  in  1  asynchronous active-high reset.
- max_digits  in  4  active digit count for the difficulty; values above NUM_DIGITS are clamped to NUM_DIGITS.
- inc_btn  in  NUM_DIGITS  raw increment buttons; bit i selects digit i.
- dec_btn  in  NUM_DIGITS  raw decrement buttons.
- confirm  in  1  raw confirm button.
- guess_ack  in  1  comparator accepts the guess (single-cycle, synchronous).
- guess_hit  in  1  qualifies guess_ack: the guess was correct.
- display_digits  out  4*NUM_DIGITS  live entry digits; digit i at bits [4i+3:4i].
- guess_digits  out  4*NUM_DIGITS  latched guess.
- guess_valid  out  1  guess pending at the comparator.
- attempts_used  out  ATTEMPT_W  acknowledged guesses, saturating.
- won  out  1  sticky; set on a hit.
- out_of_attempts  out  1  sticky; set on exhaustion.
- locked  out  1  high when won or out_of_attempts is set.

Behaviour:
- Reset: restart high asynchronously clears everything to 0. This covers all digits, guess_digits, guess_valid, attempts_used, won, out_of_attempts, the synchroniser flops and the FSM (state ENTRY).
- Input conditioning, applied to each of inc_btn, dec_btn and confirm:
  - 3-flop chain s1→s2→s3; edge = s2 & ~s3.
  - A button first sampled high at clock edge k gives edge high between edges k+1 and k+2; the action takes effect at edge k+2.
  - Holding a button produces exactly one action; release and re-press are required to act again.
- FSM states: ENTRY, PENDING, LOCKED.
- ENTRY:
  - Digit i is active when i < clamped max_digits.
  - Inc edge on an active digit: d = (d == RADIX-1) ? 0 : d+1.
  - Dec edge on an active digit: d = (d == 0) ? RADIX-1 : d-1.
  - Inc and dec edges on the same digit in the same cycle: no change. Different digits update independently in the same cycle.
  - Inactive digits are forced to 0 every cycle, including when max_digits shrinks while entering.
  - Confirm edge: guess_digits <= display_digits (pre-update values); guess_valid <= 1; go to PENDING. Any digit edges in that same cycle are discarded.
- PENDING:
  - guess_valid is held high and guess_digits is stable.
  - All button edges are discarded; display_digits is frozen.
  - On guess_ack: guess_valid <= 0 and attempts_used <= attempts_used+1, saturating at 2^ATTEMPT_W-1.
    - If guess_hit: won <= 1 → LOCKED.
    - Else if MAX_ATTEMPTS != 0 and the new attempts_used == MAX_ATTEMPTS: out_of_attempts <= 1 → LOCKED.
    - Otherwise → ENTRY. Digits are retained so the player can adjust the previous guess.
  - guess_ack in ENTRY or LOCKED is ignored.
- LOCKED:
  - All edges are ignored and outputs hold. Only restart exits this state.
- Reset mid-operation, including during PENDING: immediate clear; guess_valid drops asynchronously.
- locked = won | out_of_attempts, combinational from the registered flags.

Test Plan:
1. Defaults, max_digits=3: press inc_btn[0] 11 times with releases → digit0 = 1 (wrap 9→0). Each change lands 2 edges after the press is first sampled.
2. dec_btn[1] from 0 → digit1 = 9. inc_btn[2] and dec_btn[2] asserted together → digit2 unchanged. inc_btn[0] held for 20 cycles → exactly +1.
3. Digits set to 4,5,6, then max_digits=1 → digits 1 and 2 read 0 next cycle. inc_btn[2] is then ignored and digit0 stays 4.
4. Digits 7,2,0, press confirm → guess_digits = 0x027 and guess_valid=1. Hold off guess_ack 10 cycles while pressing inc_btn[0] → display and guess unchanged. guess_ack=1 with guess_hit=0 → guess_valid=0, attempts_used=1, state ENTRY.
5. MAX_ATTEMPTS=2: two misses → out_of_attempts=1 and locked=1; further confirm produces no guess_valid. Separately, a hit on the first guess → won=1 and attempts_used=1.
6. restart pulsed while guess_valid=1 → all outputs 0 within the same cycle, without a clock edge. A subsequent confirm yields guess_digits=0.
